// File: rtl/axis_noc_pkg.sv
// Shared constants for the AXIS-to-NoC packetizer: flit type codes, header
// field layout and FSM state encoding.
package axis_noc_pkg;

    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    // Header payload layout from bit 0 upward: cont, wakeup, seq, id, dest.
    localparam int HDR_CONT_BIT = 0;
    localparam int HDR_WAKE_BIT = 1;
    localparam int HDR_SEQ_LSB  = 2;
    localparam int HDR_SEQ_W    = 8;
    localparam int HDR_ID_LSB   = HDR_SEQ_LSB + HDR_SEQ_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_CONT = 2'd2
    } state_t;

endpackage

// File: rtl/axis_noc_packetizer_flit_reg.sv
// Single-entry output register for the NoC link. It reports when the slot is
// free, so that a new flit can load in the same cycle the old one retires.
module axis_noc_flit_reg #(
    parameter int FlitWidth = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [FlitWidth-1:0] i_flit,
    input  logic                 i_ready,
    output logic [FlitWidth-1:0] o_flit,
    output logic                 o_valid,
    output logic                 o_free
);

    logic [FlitWidth-1:0] r_flit;
    logic                 r_valid;

    assign o_free  = !r_valid || i_ready;
    assign o_flit  = r_flit;
    assign o_valid = r_valid;

    // i_load is only raised while o_free is high, so the held flit never gets overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_flit  <= i_flit;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_noc_packetizer.sv
// Turns an AXI-Stream packet into NoC flits. Each packet starts with a header
// flit, and packets longer than MaxBeats are split into continuation packets.
//
// state   | meaning
// IDLE    | waiting for the first beat; emits HEAD (cont=0) without consuming it
// BODY    | forwarding beats as BODY/TAIL flits
// CONT    | packet split at MaxBeats; emits HEAD (cont=1) from latched fields
module axis_noc_packetizer
    import axis_noc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int KeepWidth = DataWidth / 8,
    parameter int StrbWidth = DataWidth / 8,
    parameter int TidWidth  = 8,
    parameter int DestWidth = 8,
    parameter int UserWidth = DataWidth / 8,
    parameter int MaxBeats  = 16,
    parameter int FlitWidth = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DataWidth-1:0] s_axis_tdata,
    input  logic [KeepWidth-1:0] s_axis_tkeep,
    input  logic [StrbWidth-1:0] s_axis_tstrb,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [TidWidth-1:0]  s_axis_tid,
    input  logic [DestWidth-1:0] s_axis_tdest,
    input  logic [UserWidth-1:0] s_axis_tuser,
    input  logic                 s_axis_twakeup,
    output logic [FlitWidth-1:0] m_flit,
    output logic                 m_flit_valid,
    input  logic                 m_flit_ready
);

    localparam int BodyW = DataWidth + KeepWidth + StrbWidth + UserWidth;
    localparam int CntW  = $clog2(MaxBeats);
    localparam logic [CntW-1:0] LastCnt = CntW'(MaxBeats - 1);

    state_t                r_state;
    logic [HDR_SEQ_W-1:0]  r_seq;
    logic [CntW-1:0]       r_beat_cnt;
    logic [DestWidth-1:0]  r_dest;
    logic [TidWidth-1:0]   r_id;
    logic                  r_wake;

    logic                  w_free;
    logic                  w_load;
    logic                  w_accept;
    logic [FlitWidth-1:0]  w_flit;

    function automatic logic [FlitWidth-1:0] make_head(
        input logic [DestWidth-1:0] dest,
        input logic [TidWidth-1:0]  id,
        input logic [HDR_SEQ_W-1:0] seq,
        input logic                 wake,
        input logic                 cont
    );
        logic [FlitWidth-1:0] f;
        f = '0;
        f[FlitWidth-1 -: 2]                   = FLIT_HEAD;
        f[HDR_CONT_BIT]                       = cont;
        f[HDR_WAKE_BIT]                       = wake;
        f[HDR_SEQ_LSB +: HDR_SEQ_W]           = seq;
        f[HDR_ID_LSB +: TidWidth]             = id;
        f[HDR_ID_LSB + TidWidth +: DestWidth] = dest;
        return f;
    endfunction

    assign s_axis_tready = (r_state == ST_BODY) && w_free;
    assign w_accept      = s_axis_tready && s_axis_tvalid;

    always_comb begin
        w_load = 1'b0;
        w_flit = '0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid && w_free) begin
                    w_load = 1'b1;
                    w_flit = make_head(s_axis_tdest, s_axis_tid, r_seq, s_axis_twakeup, 1'b0);
                end
            end
            ST_BODY: begin
                if (w_accept) begin
                    w_load              = 1'b1;
                    w_flit[BodyW-1:0]   = {s_axis_tuser, s_axis_tstrb, s_axis_tkeep, s_axis_tdata};
                    w_flit[FlitWidth-1 -: 2] =
                        (s_axis_tlast || r_beat_cnt == LastCnt) ? FLIT_TAIL : FLIT_BODY;
                end
            end
            ST_CONT: begin
                if (w_free) begin
                    w_load = 1'b1;
                    w_flit = make_head(r_dest, r_id, r_seq, r_wake, 1'b1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_seq      <= '0;
            r_beat_cnt <= '0;
            r_dest     <= '0;
            r_id       <= '0;
            r_wake     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_tvalid && w_free) begin
                        r_dest     <= s_axis_tdest;
                        r_id       <= s_axis_tid;
                        r_wake     <= s_axis_twakeup;
                        r_seq      <= r_seq + 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (s_axis_tlast) begin
                            r_state <= ST_IDLE;
                        end else if (r_beat_cnt == LastCnt) begin
                            r_state <= ST_CONT;
                        end
                    end
                end
                ST_CONT: begin
                    if (w_free) begin
                        r_seq      <= r_seq + 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BODY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_noc_flit_reg #(
        .FlitWidth(FlitWidth)
    ) u_flit_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flit  (w_flit),
        .i_ready (m_flit_ready),
        .o_flit  (m_flit),
        .o_valid (m_flit_valid),
        .o_free  (w_free)
    );

endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Bench for axis_noc_packetizer: packet table, stall/reset/seq-wrap sequences
// and randomized traffic against a packet-level reference model.
module tb_axis_noc_packetizer;

    localparam int MB = 4;
    localparam int FW = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic [3:0]  s_axis_tstrb = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tid = '0;
    logic [7:0]  s_axis_tdest = '0;
    logic [3:0]  s_axis_tuser = '0;
    logic        s_axis_twakeup = 1'b0;
    logic [FW-1:0] m_flit;
    logic        m_flit_valid;
    logic        m_flit_ready = 1'b1;

    always #5 clk = ~clk;

    axis_noc_packetizer #(
        .MaxBeats(MB),
        .FlitWidth(FW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_twakeup (s_axis_twakeup),
        .m_flit         (m_flit),
        .m_flit_valid   (m_flit_valid),
        .m_flit_ready   (m_flit_ready)
    );

    typedef struct {
        logic [FW-1:0] flit;
        int            cyc;
    } rec_t;

    typedef struct {
        int          len;
        logic [7:0]  dest;
        logic [7:0]  id;
        logic        wake;
        logic [31:0] base;
        int          nflits;
    } vec_t;

    rec_t          rcv_q[$];
    logic [FW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic          rnd_ready = 1'b0;
    logic [7:0]    m_seq = '0;

    logic [31:0] b_data[64];
    logic [3:0]  b_keep[64];
    logic [3:0]  b_strb[64];
    logic [3:0]  b_user[64];

    vec_t tbl[7];

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_head(input logic [7:0] d, input logic [7:0] id,
                                              input logic [7:0] seq, input logic w, input logic c);
        logic [FW-1:0] f;
        f = '0;
        f[47:46] = 2'b01;
        f[25:0]  = {d, id, seq, w, c};
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_beat(input logic [1:0] t, input int i);
        logic [FW-1:0] f;
        f = '0;
        f[47:46] = t;
        f[43:0]  = {b_user[i], b_strb[i], b_keep[i], b_data[i]};
        return f;
    endfunction

    // Packet-level model: one header, then beats; split after every MB beats
    // unless that beat is the real last one.
    task automatic model_pkt(input int len, input logic [7:0] d, input logic [7:0] id, input logic w);
        int n;
        exp_q.push_back(mk_head(d, id, m_seq, w, 1'b0));
        m_seq++;
        n = 0;
        for (int i = 0; i < len; i++) begin
            n++;
            if (i == len - 1) begin
                exp_q.push_back(mk_beat(2'b10, i));
            end else if (n == MB) begin
                exp_q.push_back(mk_beat(2'b10, i));
                exp_q.push_back(mk_head(d, id, m_seq, w, 1'b1));
                m_seq++;
                n = 0;
            end else begin
                exp_q.push_back(mk_beat(2'b00, i));
            end
        end
    endtask

    task automatic fill_data(input int len, input bit rnd, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            if (rnd) begin
                b_data[i] = $urandom();
                b_keep[i] = 4'($urandom());
                b_strb[i] = 4'($urandom());
                b_user[i] = 4'($urandom());
            end else begin
                b_data[i] = base + 32'(i);
                b_keep[i] = 4'hF;
                b_strb[i] = 4'hF;
                b_user[i] = 4'(i);
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic drive_beat(input int i, input bit last, input logic [7:0] d,
                              input logic [7:0] id, input logic w);
        int wt;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = b_data[i];
        s_axis_tkeep   = b_keep[i];
        s_axis_tstrb   = b_strb[i];
        s_axis_tuser   = b_user[i];
        s_axis_tlast   = last;
        s_axis_tdest   = (i == 0) ? d  : 8'($urandom());
        s_axis_tid     = (i == 0) ? id : 8'($urandom());
        s_axis_twakeup = (i == 0) ? w  : 1'($urandom());
        wt = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            wt++;
            if (wt > 500) begin
                $display("FAIL beat_wait: tready still %b after %0d cycles, required 1", s_axis_tready, wt);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input int len, input logic [7:0] d, input logic [7:0] id,
                             input logic w, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            drive_beat(i, i == len - 1, d, id, w);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_out();
        int wt;
        wt = 0;
        while (rcv_q.size() < exp_q.size() && wt < 200) begin
            @(negedge clk);
            wt++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cmp_clear(input string name, input int want_n, input bit consec);
        int n;
        chk_int({name, "_count"}, rcv_q.size(), exp_q.size());
        if (want_n >= 0) chk_int({name, "_nflits"}, rcv_q.size(), want_n);
        if (consec && rcv_q.size() > 0)
            chk_int({name, "_span"}, rcv_q[rcv_q.size()-1].cyc - rcv_q[0].cyc, rcv_q.size() - 1);
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_flit%0d", name, i), rcv_q[i].flit, exp_q[i]);
        rcv_q.delete();
        exp_q.delete();
    endtask

    task automatic monitor();
        logic          prev_stall;
        logic [FW-1:0] prev_flit;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && prev_stall) begin
                n_tests++;
                if (!m_flit_valid || m_flit !== prev_flit) begin
                    n_fail++;
                    $display("FAIL hold_stable: flit %h valid %b, required %h valid 1", m_flit, m_flit_valid, prev_flit);
                end
            end
            prev_stall = m_flit_valid && !m_flit_ready;
            prev_flit  = m_flit;
            if (m_flit_valid && m_flit_ready) rcv_q.push_back('{m_flit, cyc});
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_flit_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        fork
            monitor();
            ready_gen();
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        tbl[0] = '{3, 8'h05, 8'h02, 1'b0, 32'h0,  4};
        tbl[1] = '{1, 8'h11, 8'h22, 1'b1, 32'hA5, 2};
        tbl[2] = '{6, 8'h33, 8'h44, 1'b0, 32'h100, 8};
        tbl[3] = '{4, 8'h7E, 8'h81, 1'b1, 32'h200, 5};
        tbl[4] = '{5, 8'hC3, 8'h3C, 1'b0, 32'h300, 7};
        tbl[5] = '{8, 8'hFF, 8'h00, 1'b1, 32'h400, 10};
        tbl[6] = '{2, 8'h00, 8'hFF, 1'b0, 32'h500, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flit",   m_flit, '0);
        chk("rst_valid",  FW'(m_flit_valid), '0);
        chk("rst_tready", FW'(s_axis_tready), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            fill_data(tbl[k].len, 1'b0, tbl[k].base);
            model_pkt(tbl[k].len, tbl[k].dest, tbl[k].id, tbl[k].wake);
            drive_pkt(tbl[k].len, tbl[k].dest, tbl[k].id, tbl[k].wake, 1'b0);
            wait_out();
            if (k == 0 && rcv_q.size() > 0) chk("first_head", rcv_q[0].flit, 48'h4000_0014_0800);
            if (k == 1 && rcv_q.size() > 1) chk("single_tail", rcv_q[1].flit, 48'h80FF_0000_00A5);
            cmp_clear($sformatf("tbl%0d", k), tbl[k].nflits, 1'b1);
        end

        // Output stall right after the HEAD
        fill_data(3, 1'b0, 32'h10);
        model_pkt(3, 8'h5A, 8'hA5, 1'b1);
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = b_data[0];
        s_axis_tkeep   = b_keep[0];
        s_axis_tstrb   = b_strb[0];
        s_axis_tuser   = b_user[0];
        s_axis_tlast   = 1'b0;
        s_axis_tdest   = 8'h5A;
        s_axis_tid     = 8'hA5;
        s_axis_twakeup = 1'b1;
        @(negedge clk);
        chk("idle_tready", FW'(s_axis_tready), '0);
        @(posedge clk);
        #1;
        m_flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_head%0d", i), m_flit, exp_q[0]);
            chk($sformatf("stall_valid%0d", i), FW'(m_flit_valid), FW'(1));
            chk($sformatf("stall_tready%0d", i), FW'(s_axis_tready), '0);
            @(posedge clk);
            #1;
        end
        m_flit_ready = 1'b1;
        drive_pkt(3, 8'h5A, 8'hA5, 1'b1, 1'b0);
        wait_out();
        cmp_clear("stall", 4, 1'b0);

        // Reset mid-packet after the second body beat
        fill_data(3, 1'b0, 32'h20);
        drive_beat(0, 1'b0, 8'h12, 8'h34, 1'b0);
        drive_beat(1, 1'b0, 8'h12, 8'h34, 1'b0);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        chk("midrst_flit",   m_flit, '0);
        chk("midrst_valid",  FW'(m_flit_valid), '0);
        chk("midrst_tready", FW'(s_axis_tready), '0);
        rcv_q.delete();
        exp_q.delete();
        m_seq = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_data(2, 1'b0, 32'h30);
        model_pkt(2, 8'h66, 8'h77, 1'b0);
        drive_pkt(2, 8'h66, 8'h77, 1'b0, 1'b0);
        wait_out();
        if (rcv_q.size() > 0) chk("post_rst_seq", FW'(rcv_q[0].flit[9:2]), '0);
        cmp_clear("post_rst", 3, 1'b1);

        // Randomized traffic with source gaps and output back-pressure
        rnd_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int          len;
            logic [7:0]  d;
            logic [7:0]  id;
            logic        w;
            len = $urandom_range(1, 10);
            d   = 8'($urandom());
            id  = 8'($urandom());
            w   = 1'($urandom());
            fill_data(len, 1'b1, '0);
            model_pkt(len, d, id, w);
            drive_pkt(len, d, id, w, 1'b1);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        m_flit_ready = 1'b1;
        wait_out();
        cmp_clear("random", -1, 1'b0);

        // Sequence number wrap over 257 single-beat packets
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_seq = '0;
        @(posedge clk);
        #1;
        for (int p = 0; p < 257; p++) begin
            fill_data(1, 1'b1, '0);
            model_pkt(1, 8'(p), 8'(p * 3), 1'b0);
            drive_pkt(1, 8'(p), 8'(p * 3), 1'b0, 1'b0);
        end
        wait_out();
        if (rcv_q.size() > 512) begin
            chk("seq_255", FW'(rcv_q[510].flit[9:2]), FW'(8'hFF));
            chk("seq_wrap", FW'(rcv_q[512].flit[9:2]), '0);
        end
        cmp_clear("wrap", 514, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
